// File: rtl/usr_shift_pkg.sv
// Shared encodings for the universal shift register slice.
// Mode, fill and FSM state definitions.
package usr_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] FILL_SER   = 2'b00;
  localparam logic [1:0] FILL_ROT   = 2'b01;
  localparam logic [1:0] FILL_ARITH = 2'b10;
  localparam logic [1:0] FILL_ZERO  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/usr_shift_seq_if.sv
// Control/data bundle of usr_shift_seq.
// master: drives mode/fill/din/serial/start/dir/cnt; slave: drives q/ser_out/busy/done.
interface usr_shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [1:0]       mode;
  logic [1:0]       fill;
  logic [WIDTH-1:0] din;
  logic             ser_in_msb;
  logic             ser_in_lsb;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output mode, fill, din, ser_in_msb, ser_in_lsb,
    output start, dir, cnt,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  mode, fill, din, ser_in_msb, ser_in_lsb,
    input  start, dir, cnt,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 mux (hold/left/right/din) and flop.
// Ports: clk, rst, sel, left_i (bit above), right_i (bit below), din_i, q_o.
module usr_bit_cell
  import usr_shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       din_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case (sel)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = left_i;
      MODE_SHL:  q_d = right_i;
      default:   q_d = din_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_shift_seq.sv
// Universal shift register with selectable fill and counted-shift engine.
// Ports: clk, rst (sync, active-high), bus (slave side of usr_shift_seq_if).
module usr_shift_seq
  import usr_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  usr_shift_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       fill_q, fill_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] q_w;
  logic [1:0]       sel;
  logic [1:0]       eff_fill;
  logic             fill_r;
  logic             fill_l;

  // Engine owns the datapath while running; start
  // then suppresses mode for its own cycle.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    done_d    = 1'b0;
    sel       = MODE_HOLD;
    eff_fill  = bus.fill;
    ser_out_d = ser_out_q;
    if (state_q == RUN) begin
      sel      = dir_q ? MODE_SHL : MODE_SHR;
      eff_fill = fill_q;
      rem_d    = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (bus.start) begin
      if (bus.cnt != '0) begin
        state_d = RUN;
        rem_d   = bus.cnt;
        dir_d   = bus.dir;
        fill_d  = bus.fill;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      sel = bus.mode;
    end
    unique case (sel)
      MODE_SHR: ser_out_d = q_w[0];
      MODE_SHL: ser_out_d = q_w[WIDTH-1];
      default:  ser_out_d = ser_out_q;
    endcase
  end

  always_comb begin
    fill_r = 1'b0;
    fill_l = 1'b0;
    unique case (eff_fill)
      FILL_SER: begin
        fill_r = bus.ser_in_msb;
        fill_l = bus.ser_in_lsb;
      end
      FILL_ROT: begin
        fill_r = q_w[0];
        fill_l = q_w[WIDTH-1];
      end
      FILL_ARITH: begin
        fill_r = q_w[WIDTH-1];
        fill_l = 1'b0;
      end
      default: begin
        fill_r = 1'b0;
        fill_l = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic left_w;
    logic right_w;
    if (i == WIDTH - 1) begin : g_top
      assign left_w = fill_r;
    end else begin : g_mid_l
      assign left_w = q_w[i+1];
    end
    if (i == 0) begin : g_bot
      assign right_w = fill_l;
    end else begin : g_mid_r
      assign right_w = q_w[i-1];
    end
    usr_bit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .left_i  (left_w),
      .right_i (right_w),
      .din_i   (bus.din[i]),
      .q_o     (q_w[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      fill_q    <= FILL_SER;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      fill_q    <= fill_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  assign bus.q       = q_w;
  assign bus.ser_out = ser_out_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_usr_shift_seq.sv
// Scoreboard bench for usr_shift_seq.
// Directed plan items plus randomized traffic against a behavioural model.
module tb_usr_shift_seq;

  localparam int W = 8;
  localparam int C = 4;

  typedef struct {
    logic [W-1:0] q;
    logic         so;
    logic         busy;
    logic         done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usr_shift_seq_if #(.WIDTH(W), .CNT_W(C)) bus ();

  usr_shift_seq #(.WIDTH(W), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t sb[$];

  // behavioural model
  logic [W-1:0] m_q    = '0;
  logic         m_so   = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_left = 0;
  logic         m_dir  = 1'b0;
  logic [1:0]   m_fill = 2'b00;

  task automatic m_shift(input logic left, input logic [1:0] f);
    logic b;
    if (!left) begin
      case (f)
        2'd0: b = bus.ser_in_msb;
        2'd1: b = m_q[0];
        2'd2: b = m_q[W-1];
        default: b = 1'b0;
      endcase
      m_so = m_q[0];
      m_q  = (m_q >> 1) | ({{(W-1){1'b0}}, b} << (W - 1));
    end else begin
      case (f)
        2'd0: b = bus.ser_in_lsb;
        2'd1: b = m_q[W-1];
        default: b = 1'b0;
      endcase
      m_so = m_q[W-1];
      m_q  = (m_q << 1) | {{(W-1){1'b0}}, b};
    end
  endtask

  task automatic model_step();
    exp_t e;
    m_done = 1'b0;
    if (rst) begin
      m_q = '0; m_so = 1'b0; m_busy = 1'b0; m_left = 0;
    end else if (m_busy) begin
      m_shift(m_dir, m_fill);
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (bus.start) begin
      if (bus.cnt == 0) m_done = 1'b1;
      else begin
        m_busy = 1'b1;
        m_left = int'(bus.cnt);
        m_dir  = bus.dir;
        m_fill = bus.fill;
      end
    end else begin
      case (bus.mode)
        2'd1: m_shift(1'b0, bus.fill);
        2'd2: m_shift(1'b1, bus.fill);
        2'd3: m_q = bus.din;
        default: ;
      endcase
    end
    e.q = m_q; e.so = m_so; e.busy = m_busy; e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [1:0] md, input logic [1:0] fl,
                       input logic [W-1:0] d, input logic msb,
                       input logic lsb, input logic st,
                       input logic dr, input logic [C-1:0] cn);
    bus.mode = md; bus.fill = fl; bus.din = d;
    bus.ser_in_msb = msb; bus.ser_in_lsb = lsb;
    bus.start = st; bus.dir = dr; bus.cnt = cn;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'd0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // monitor: one expected snapshot per clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if (bus.q !== e.q || bus.ser_out !== e.so ||
            bus.busy !== e.busy || bus.done !== e.done) begin
          n_fail++;
          $display("FAIL sb t=%0t: got q=%h so=%b busy=%b done=%b exp q=%h so=%b busy=%b done=%b",
                   $time, bus.q, bus.ser_out, bus.busy, bus.done,
                   e.q, e.so, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.mode = 2'd0; bus.fill = 2'd0; bus.din = '0;
    bus.ser_in_msb = 1'b0; bus.ser_in_lsb = 1'b0;
    bus.start = 1'b0; bus.dir = 1'b0; bus.cnt = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_q", bus.q, 8'h00);
    chk("rst_flags", {5'b0, bus.ser_out, bus.busy, bus.done}, 8'h00);

    drive(2'd3, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("load", bus.q, 8'hA5);
    drive(2'd1, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("shr_q", bus.q, 8'hD2);
    chk("shr_so", {7'b0, bus.ser_out}, 8'h01);
    drive(2'd2, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("shl_q", bus.q, 8'hA4);
    chk("shl_so", {7'b0, bus.ser_out}, 8'h01);

    drive(2'd3, 2'd0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(2'd0, 2'd1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    chk("rot_e0", bus.q, 8'h81);
    idle(1); chk("rot_1", bus.q, 8'hC0);
    idle(1); chk("rot_2", bus.q, 8'h60);
    idle(1); chk("rot_3", bus.q, 8'h30);
    chk("rot_done", {6'b0, bus.busy, bus.done}, 8'h01);
    idle(1);

    drive(2'd3, 2'd0, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(2'd0, 2'd2, '0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    idle(1); chk("ari_1", bus.q, 8'hC8);
    idle(1); chk("ari_2", bus.q, 8'hE4);
    chk("ari_done", {7'b0, bus.done}, 8'h01);
    idle(1);

    drive(2'd0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("cnt0", {6'b0, bus.busy, bus.done}, 8'h01);
    chk("cnt0_q", bus.q, 8'hE4);
    idle(1);

    drive(2'd0, 2'd3, '0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
    idle(1);
    drive(2'd3, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
    idle(2);
    chk("ign_q", bus.q, 8'h40);
    chk("ign_done", {6'b0, bus.busy, bus.done}, 8'h01);
    idle(1);

    drive(2'd3, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(2'd0, 2'd1, '0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    idle(9);
    chk("rol9", bus.q, 8'h02);
    idle(1);

    drive(2'd3, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(2'd0, 2'd1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("abort", {bus.q[5:0], bus.busy, bus.done}, 8'h00);
    idle(5);
    drive(2'd3, 2'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(2'd0, 2'd3, '0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
    idle(2);
    chk("fresh", bus.q, 8'h3C);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive(2'($urandom), 2'($urandom), W'($urandom),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), 1'($urandom),
            C'($urandom));
    end
    rst = 1'b0;
    idle(20);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_shift_seq.md
Name: usr_shift_seq

Overview:
Parametrised universal shift register: WIDTH-bit register with hold, shift right, shift left and parallel load. Adds selectable fill (serial, rotate, arithmetic, zero) and a counted-shift engine that performs N shifts autonomously with a busy/done handshake. Serves as the general-purpose shift/serialiser block for datapath and serial-transfer logic; supersedes the fixed 8-bit shifter.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of the shift-count input; counts 0 .. 2^CNT_W-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
mode  in  2  direct op when idle: 00 hold, 01 shift right, 10 shift left, 11 parallel load din
fill  in  2  vacated-bit source: 00 serial input, 01 rotate, 10 arithmetic, 11 zero
din  in  WIDTH  parallel load data
ser_in_msb  in  1  bit entering q[WIDTH-1] on right shift when fill=00
ser_in_lsb  in  1  bit entering q[0] on left shift when fill=00
start  in  1  request counted shift; sampled only when idle
dir  in  1  counted-shift direction: 0 right, 1 left
cnt  in  CNT_W  number of counted shifts
q  out  WIDTH  register contents
ser_out  out  1  bit most recently shifted out
busy  out  1  counted shift in progress
done  out  1  one-cycle pulse: counted shift complete

Behaviour:
- Reset (rst=1 at edge): q=0, ser_out=0, busy=0, done=0, state IDLE, remaining count=0. Overrides everything, including mid-run; an aborted run produces no done pulse.
- Shift right: q <= {F, q[WIDTH-1:1]}; ser_out <= q[0]. Shift left: q <= {q[WIDTH-2:0], F}; ser_out <= q[WIDTH-1].
- Fill F, right: 00 ser_in_msb; 01 q[0]; 10 q[WIDTH-1] (sign extend); 11 0. Fill F, left: 00 ser_in_lsb; 01 q[WIDTH-1]; 10 0; 11 0.
- Hold and load leave ser_out unchanged. Load: q <= din.
- States: IDLE, RUN. done is a registered output; it defaults to 0 every cycle unless set below.
- IDLE, start=1, cnt!=0: at edge E0 latch dir, fill and cnt into internal regs; go to RUN; busy=1; q unchanged at E0.
- RUN: one shift per edge using the latched dir/fill. ser_in_* is sampled live each shift. Remaining count decrements each edge. The shift at edge En (n = cnt) is the last; at En go to IDLE, busy=0, done=1 for exactly one cycle.
- Net result: busy high for cnt cycles; done high the cycle after busy falls. done and busy are never high together.
- IDLE, start=1, cnt=0: no shift; done=1 the next cycle; busy stays 0.
- Priority: rst > RUN engine > start > mode. In RUN, start and mode are ignored. In IDLE, start=1 suppresses mode for that cycle.
- cnt may exceed WIDTH: shifts are performed exactly cnt times, which is meaningful for rotate.
- start asserted in the same cycle done is high is accepted, since the state is IDLE.

Decomposition:
- Package usr_shift_pkg:
  - mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD
  - fill encodings FILL_SER, FILL_ROT, FILL_ARITH, FILL_ZERO
  - state enum {IDLE, RUN}
- Sub-module usr_bit_cell: per-bit 4:1 next-value mux (hold / left neighbour / right neighbour / din) plus flop with sync reset, replicated WIDTH times by generate.
- Fill logic, counter and FSM live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles -> q=0x00, ser_out=0, busy=0, done=0.
- Direct ops (WIDTH=8):
  - mode=11, din=0xA5 -> q=0xA5.
  - Then mode=01, fill=00, ser_in_msb=1 -> q=0xD2, ser_out=1.
  - Then mode=10, ser_in_lsb=0 -> q=0xA4, ser_out=1.
- Counted rotate: load 0x81; start, dir=0, fill=01, cnt=3 -> busy 3 cycles, q steps 0xC0, 0x60, 0x30; done one cycle after busy falls; final q=0x30.
- Counted arithmetic: load 0x90; start, dir=0, fill=10, cnt=2 -> q 0xC8 then 0xE4; done pulse.
- Edge cases:
  - start with cnt=0 -> done next cycle, busy=0, q unchanged.
  - During a cnt=4 run, pulse start and mode=11 with din=0xFF -> both ignored; run completes normally.
  - Load 0x01, rotate left cnt=9 -> q=0x02.
- Reset mid-run: start cnt=5, assert rst after the 2nd shift -> q=0, busy=0 next cycle, done never pulses; a fresh start afterwards behaves normally.
